hazard_pipe_tracker: RTL
========================

HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the performance-counter width.
REQ-002 SHALL have these ports, one per line as name / direction / width / meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_valid_IF  in  1  fetch stage holds a real instruction.
- rd_ID  in  5  destination register of the ID instruction.
- rs2_ID  in  5  rs2 of the ID instruction.
- regwrite_ID  in  1  ID instruction writes rd.
- hazard_optype_ID  in  2  hazard type: 00 none, 01 data, 10 load, 11 store.
- reg_FD_EN, reg_FD_stall, reg_FD_flush  in  1 each  F/D register controls from hazard detection.
- reg_DE_EN, reg_DE_flush  in  1 each  D/E register controls.
- reg_EM_EN, reg_EM_flush  in  1 each  E/M register controls.
- reg_MW_EN  in  1  M/W enable.
- cnt_clr  in  1  synchronous clear of all counters.
- valid_ID, valid_EXE, valid_MEM, valid_WB  out  1 each  stage holds a real instruction.
- rd_EXE, rd_MEM, rd_WB  out  5 each  tracked destination registers.
- rs2_EXE  out  5  rs2 of the EXE instruction.
- optype_EXE, optype_MEM, optype_WB  out  2 each  tracked hazard types.
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  performance counters.

Function
REQ-003 All outputs SHALL be registered; there are no combinational input-to-output paths.
REQ-004 F/D register update priority SHALL be:
- reg_FD_flush: valid_ID<=0.
- else reg_FD_stall, or reg_FD_EN=0: hold.
- else valid_ID<=inst_valid_IF.
REQ-005 D/E register update priority SHALL be:
- reg_DE_flush: bubble.
- else reg_DE_EN=1: load from ID.
- else hold.
REQ-006 A load from ID SHALL capture the following:
- valid_EXE<=valid_ID.
- rd_EXE<=rd_ID if regwrite_ID and valid_ID and rd_ID!=0, else 0.
- rs2_EXE<=rs2_ID.
- optype_EXE<=hazard_optype_ID if valid_ID, else 00.
REQ-007 A bubble SHALL set valid=0, rd=0, rs2=0, optype=00 in the target stage.
REQ-008 E/M register update priority SHALL be:
- reg_EM_flush: bubble.
- else reg_EM_EN: copy EXE fields.
- else hold.
REQ-009 M/W SHALL copy MEM fields when reg_MW_EN=1 and hold otherwise.
REQ-010 Flush SHALL take priority over stall and over EN in the same cycle.
REQ-011 Fields SHALL advance one stage per enabled cycle: an ID instruction appears in EXE at cycle+1, MEM at +2 and WB at +3 when not stalled.
REQ-012 stall_cnt SHALL increment on each cycle with reg_FD_stall=1 and reg_FD_flush=0.
REQ-013 flush_cnt SHALL increment on each cycle with reg_FD_flush=1 and valid_ID=1.
REQ-014 retire_cnt SHALL increment on each cycle with valid_WB=1.
REQ-015 Counters SHALL saturate at all-ones and never wrap.
REQ-016 cnt_clr SHALL zero all counters at the next edge and win over any simultaneous increment.

Reset
REQ-017 On rst_n=0, every stage SHALL asynchronously become a bubble and every counter 0, so all outputs read 0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state, with no delayed completion after release.
REQ-019 The first capture after release SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-020 The hazard optype encodings (NONE=00, DATA=01, LOAD=10, STORE=11) and the bubble field values SHALL live in the shared core package, the same package the hazard detection unit uses.
REQ-021 One sub-module, hazard_stage_reg, SHALL implement a single flush/EN stage register holding {valid, rd, rs2, optype}, instantiated three times.
REQ-022 The counters SHALL be inline, with no separate module.

Verification
REQ-023 Straight-line flow: inst_valid_IF=1, rd_ID=5, regwrite_ID=1, optype 01, all EN=1, no stall/flush -> rd_EXE=5 at +1, rd_MEM=5 at +2, rd_WB=5 at +3, retire_cnt=1 at +4.
REQ-024 Load-use stall: load rd=7 in ID, then one cycle of reg_FD_stall=1 with reg_DE_flush=1 -> valid_ID held, bubble (rd_EXE=0, optype 00) inserted, stall_cnt=1.
REQ-025 Flush beats stall: reg_FD_flush=1 and reg_FD_stall=1 in the same cycle with valid_ID=1 -> valid_ID=0, flush_cnt=1, stall_cnt unchanged.
REQ-026 x0 filter: rd_ID=0, regwrite_ID=1, optype 01 -> rd_EXE=0; regwrite_ID=0 with rd_ID=9 -> rd_EXE=0.
REQ-027 Saturation and clear: with CNT_W=4, force 20 stall cycles -> stall_cnt=15; cnt_clr asserted together with a stall -> stall_cnt=0.
REQ-028 Async reset: pulse rst_n low between edges mid-pipeline -> all outputs 0 immediately, and a fresh instruction flows normally after release.

Source files
------------

// File: rtl/hazard_pipe_tracker_pkg.sv
// Shared core package for the hazard detection unit and the pipeline tracker.
// Holds the hazard optype encodings, the tracked stage record, the bubble
// value written by a flush, and the ID-stage capture helper.
package hazard_pipe_tracker_pkg;

    typedef enum logic [1:0] {
        HZ_NONE  = 2'b00,
        HZ_DATA  = 2'b01,
        HZ_LOAD  = 2'b10,
        HZ_STORE = 2'b11
    } hz_optype_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs2;
        hz_optype_e optype;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, rd: 5'd0, rs2: 5'd0, optype: HZ_NONE};

    // Fields captured when the ID instruction enters EXE. rd is zeroed unless
    // the instruction really writes a non-x0 register, so downstream
    // forwarding compares never match on x0 or on non-writing instructions.
    function automatic stage_t id_capture(input logic       valid,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs2,
                                          input logic       regwrite,
                                          input logic [1:0] optype);
        stage_t s;
        s.valid  = valid;
        s.rd     = (regwrite && valid && (rd != 5'd0)) ? rd : 5'd0;
        s.rs2    = rs2;
        s.optype = valid ? hz_optype_e'(optype) : HZ_NONE;
        return s;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage register of the tracker: {valid, rd, rs2, optype}.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (reset -> bubble)
//   flush      : load a bubble (wins over en)
//   en         : load d; otherwise hold
//   d, q       : stage record in / registered out
module hazard_stage_reg
    import hazard_pipe_tracker_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= STAGE_BUBBLE;
        else if (flush) q <= STAGE_BUBBLE;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Tracks which pipeline stages hold real instructions together with their
// destination register, rs2 and hazard type, mirroring the F/D, D/E, E/M and
// M/W register controls issued by hazard detection. Also keeps saturating
// stall / flush / retire performance counters.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   inst_valid_IF              : fetch holds a real instruction
//   rd_ID, rs2_ID, regwrite_ID, hazard_optype_ID : ID instruction fields
//   reg_*_EN / _stall / _flush : stage register controls
//   cnt_clr                    : synchronous clear of all counters
//   valid_*, rd_*, rs2_EXE, optype_* : registered tracked stage fields
//   stall_cnt, flush_cnt, retire_cnt : saturating counters, CNT_W bits
module hazard_pipe_tracker
    import hazard_pipe_tracker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid_IF,
    input  logic [4:0]       rd_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             regwrite_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             reg_FD_EN,
    input  logic             reg_FD_stall,
    input  logic             reg_FD_flush,
    input  logic             reg_DE_EN,
    input  logic             reg_DE_flush,
    input  logic             reg_EM_EN,
    input  logic             reg_EM_flush,
    input  logic             reg_MW_EN,
    input  logic             cnt_clr,
    output logic             valid_ID,
    output logic             valid_EXE,
    output logic             valid_MEM,
    output logic             valid_WB,
    output logic [4:0]       rd_EXE,
    output logic [4:0]       rd_MEM,
    output logic [4:0]       rd_WB,
    output logic [4:0]       rs2_EXE,
    output logic [1:0]       optype_EXE,
    output logic [1:0]       optype_MEM,
    output logic [1:0]       optype_WB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    stage_t de_d, de_q, em_q, mw_q;

    // F/D: only the valid bit is tracked here; the ID fields arrive as inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           valid_ID <= 1'b0;
        else if (reg_FD_flush)                valid_ID <= 1'b0;
        else if (reg_FD_stall || !reg_FD_EN)  valid_ID <= valid_ID;
        else                                  valid_ID <= inst_valid_IF;
    end

    assign de_d = id_capture(valid_ID, rd_ID, rs2_ID, regwrite_ID, hazard_optype_ID);

    hazard_stage_reg u_de (
        .clk(clk), .rst_n(rst_n), .flush(reg_DE_flush), .en(reg_DE_EN), .d(de_d), .q(de_q)
    );
    hazard_stage_reg u_em (
        .clk(clk), .rst_n(rst_n), .flush(reg_EM_flush), .en(reg_EM_EN), .d(de_q), .q(em_q)
    );
    // M/W has no flush control.
    hazard_stage_reg u_mw (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .en(reg_MW_EN), .d(em_q), .q(mw_q)
    );

    assign valid_EXE  = de_q.valid;
    assign valid_MEM  = em_q.valid;
    assign valid_WB   = mw_q.valid;
    assign rd_EXE     = de_q.rd;
    assign rd_MEM     = em_q.rd;
    assign rd_WB      = mw_q.rd;
    assign rs2_EXE    = de_q.rs2;
    assign optype_EXE = de_q.optype;
    assign optype_MEM = em_q.optype;
    assign optype_WB  = mw_q.optype;

    // Performance counters: saturate at all-ones, clear wins over increment.
    logic stall_inc, flush_inc, retire_inc;
    assign stall_inc  = reg_FD_stall && !reg_FD_flush;
    assign flush_inc  = reg_FD_flush && valid_ID;
    assign retire_inc = valid_WB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (stall_inc  && (stall_cnt  != '1)) stall_cnt  <= stall_cnt  + CNT_W'(1);
            if (flush_inc  && (flush_cnt  != '1)) flush_cnt  <= flush_cnt  + CNT_W'(1);
            if (retire_inc && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule
